vga_fb_arbiter: RTL

- Shares one single-port framebuffer RAM (1-cycle read latency) between two requesters: VGA scan-out prefetch and a host pixel writer.
- Sits between the framebuffer RAM, the vga_counters timing outputs (hcount/vcount) and the vga colour register.
- Prefetches pixels into a small FIFO and presents one pixel per VGA pixel slot on pixel_color.
- Display fetch has absolute priority; the host gets every cycle the display does not need.

---
 rtl/vga_fb_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/vga_fb_arbiter.sv
// ============================================================================
// Module   : vga_fb_arbiter
// Brief    : Shares a single-port framebuffer RAM between VGA scan-out
//            prefetch (absolute priority) and a host pixel writer.
//            Optional macro VGA_FB_TEST_PATTERN_EN adds pattern_en colour bars.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vga_fb_arbiter #(
    parameter int AW         = 19,
    parameter int DW         = 24,
    parameter int FIFO_DEPTH = 8,
    parameter int H_PIXELS   = 640,
    parameter int V_LINES    = 480,
    parameter int VTOTAL     = 525
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [10:0]   hcount,
    input  logic [9:0]    vcount,
`ifdef VGA_FB_TEST_PATTERN_EN
    input  logic          pattern_en,
`endif
    output logic [DW-1:0] pixel_color,
    input  logic          host_valid,
    output logic          host_ready,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_data,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          underrun
);

    localparam int              c_PW       = $clog2(FIFO_DEPTH);
    localparam int              c_CW       = DW / 3;
    localparam logic [AW-1:0]   c_FB_WORDS = AW'(H_PIXELS * V_LINES);
    localparam logic [11:0]     c_HACT     = 12'(2 * H_PIXELS);
    localparam logic [9:0]      c_VACT     = 10'(V_LINES);
    localparam logic [9:0]      c_VLAST    = 10'(VTOTAL - 1);
    localparam logic [c_PW+1:0] c_DEPTH    = (c_PW + 2)'(FIFO_DEPTH);

    logic [AW-1:0]   r_fetch_idx;
    logic            r_inflight;
    logic [c_PW:0]   r_wr_ptr;
    logic [c_PW:0]   r_rd_ptr;
    logic [DW-1:0]   r_fifo [FIFO_DEPTH];

    logic [c_PW:0]   w_occ;
    logic [c_PW+1:0] w_pending;
    logic            w_active;
    logic            w_restart;
    logic            w_pop_slot;
    logic            w_fifo_empty;
    logic            w_fetch_block;
    logic            w_fetch_go;
    logic            w_pat_show;
    logic [DW-1:0]   w_bar_color;

    assign w_occ        = r_wr_ptr - r_rd_ptr;
    assign w_pending    = {1'b0, w_occ} + {{(c_PW + 1){1'b0}}, r_inflight};
    assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
    assign w_active     = ({1'b0, hcount} < c_HACT) && (vcount < c_VACT);
    assign w_restart    = (vcount == c_VLAST) && (hcount == 11'd0);
    assign w_pop_slot   = w_active && !hcount[0];

`ifdef VGA_FB_TEST_PATTERN_EN
    logic       r_pat_lock;
    logic [2:0] w_bar;

    // Fetch stays parked after pattern_en drops until the next frame restart.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pat_lock <= 1'b0;
        end else if (pattern_en) begin
            r_pat_lock <= 1'b1;
        end else if (w_restart) begin
            r_pat_lock <= 1'b0;
        end
    end

    assign w_bar         = hcount[10:8];
    assign w_bar_color   = DW'({{c_CW{w_bar[2]}}, {c_CW{w_bar[1]}}, {c_CW{w_bar[0]}}});
    assign w_pat_show    = pattern_en;
    assign w_fetch_block = pattern_en | r_pat_lock;
`else
    assign w_bar_color   = '0;
    assign w_pat_show    = 1'b0;
    assign w_fetch_block = 1'b0;
`endif

    // Occupancy plus the read in flight bounds the FIFO, so a push never overflows.
    assign w_fetch_go = (r_fetch_idx < c_FB_WORDS) && (w_pending < c_DEPTH)
                        && !w_fetch_block && !w_restart;

    always_comb begin
        host_ready = !w_fetch_go;
        mem_addr   = r_fetch_idx;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        if (!w_fetch_go) begin
            mem_addr  = host_addr;
            mem_wdata = host_data;
            mem_we    = host_valid && (host_addr < c_FB_WORDS);
        end
    end

    always_ff @(posedge clk) begin
        if (r_inflight && !w_restart) begin
            r_fifo[r_wr_ptr[c_PW-1:0]] <= mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_idx <= '0;
            r_inflight  <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            pixel_color <= '0;
            underrun    <= 1'b0;
        end else if (w_restart) begin
            r_fetch_idx <= '0;
            r_inflight  <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            pixel_color <= '0;
        end else begin
            r_inflight <= w_fetch_go;
            if (w_fetch_go) begin
                r_fetch_idx <= r_fetch_idx + 1'b1;
            end
            if (r_inflight) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (!w_active) begin
                pixel_color <= '0;
            end else if (w_pop_slot) begin
                if (w_pat_show) begin
                    pixel_color <= w_bar_color;
                end else if (!w_fifo_empty) begin
                    pixel_color <= r_fifo[r_rd_ptr[c_PW-1:0]];
                    r_rd_ptr    <= r_rd_ptr + 1'b1;
                end else begin
                    pixel_color <= '0;
                    underrun    <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire
